// File: rtl/kp_i2s_tx.sv
// kp_i2s_tx -- mono I2S transmitter for the KP voice output.
// The block divides m_clk down to bclk and sends 64 bclk per frame. A 24-bit
// word goes out MSB first, one bit after each lrclk edge, and the same word
// is sent in both the left and the right slots. Samples enter a 2-entry FIFO,
// which is popped once per frame.
// Optional build macro: KP_I2S_UNDERRUN_HOLD_EN. When it is defined, a frame
// load that finds the FIFO empty repeats the last word sent. When it is not
// defined, that frame load sends 0.
module kp_i2s_tx #(
    parameter int BCLK_HALF = 1
) (
    input  logic        m_clk,
    input  logic        reset,
    input  logic [23:0] sample_in,
    input  logic        sample_valid,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        frame_start,
    output logic        underrun,
    output logic        overrun
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF - 1);

    // bit clock generation
    logic [7:0]  r_div;
    logic        r_bclk;

    // serialiser state
    logic [5:0]  r_bit_cnt;
    logic        r_lrclk;
    logic        r_sdata;
    logic [23:0] r_frame_word;
    logic [23:0] r_last_sample;
    logic        r_frame_start;

    // sample FIFO
    logic [1:0][23:0] r_fifo;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        r_primed;

    // sticky status
    logic        r_underrun;
    logic        r_overrun;

    // combinational helpers
    logic        w_div_wrap;
    logic        w_fall;
    logic [5:0]  w_bit_nxt;
    logic [4:0]  w_pos;
    logic [4:0]  w_idx;
    logic        w_serial_bit;
    logic        w_load;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_underrun_load;
    logic [23:0] w_load_word;

    assign w_div_wrap      = (r_div == DIV_LAST);
    // A falling transition happens when the divider wraps while bclk is high.
    assign w_fall          = w_div_wrap & r_bclk;
    assign w_bit_nxt       = r_bit_cnt + 6'd1;
    assign w_load          = w_fall & (r_bit_cnt == 6'd63);
    assign w_empty         = (r_count == 2'd0);
    assign w_full          = (r_count == 2'd2);
    assign w_pop           = w_load & ~w_empty;
    // When the FIFO is full, a push can still go in if a pop frees a slot in the same cycle.
    assign w_push          = sample_valid & (~w_full | w_pop);
    assign w_drop          = sample_valid & w_full & ~w_pop;
    assign w_underrun_load = w_load & w_empty & r_primed;

    // Slot position of the bit that goes on the wire at this falling transition.
    assign w_pos = w_bit_nxt[4:0];
    assign w_idx = 5'd24 - w_pos;

    // Position 0 is the I2S one-bit delay. Positions 1..24 carry the word and 25..31 pad with zeros.
    always_comb begin
        w_serial_bit = 1'b0;
        if ((w_pos != 5'd0) && (w_pos <= 5'd24)) begin
            w_serial_bit = r_frame_word[w_idx];
        end
    end

    // Choose the word for a frame load: the FIFO head if there is one, otherwise the underrun fill.
    always_comb begin
        w_load_word = 24'd0;
        if (!w_empty) begin
            w_load_word = r_fifo[r_rd_ptr];
        end else if (r_primed) begin
`ifdef KP_I2S_UNDERRUN_HOLD_EN
            w_load_word = r_last_sample;
`else
            w_load_word = 24'd0;
`endif
        end
    end

    // Divider and bit clock: bclk toggles each time the divider wraps.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            r_div  <= 8'd0;
            r_bclk <= 1'b0;
        end else if (w_div_wrap) begin
            r_div  <= 8'd0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + 8'd1;
        end
    end

    // Bit counter, word select and serial data all change on bclk falling transitions.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            r_bit_cnt <= 6'd0;
            r_lrclk   <= 1'b0;
            r_sdata   <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_nxt;
            r_lrclk   <= w_bit_nxt[5];
            r_sdata   <= w_serial_bit;
        end
    end

    // Two-entry sample FIFO. It pops at each frame load and pushes on each accepted strobe.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            r_fifo   <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_primed <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= sample_in;
                r_wr_ptr         <= ~r_wr_ptr;
                r_primed         <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame load: latch the next word and pulse frame_start for one cycle.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            r_frame_word  <= 24'd0;
            r_last_sample <= 24'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_load;
            if (w_load) begin
                r_frame_word  <= w_load_word;
                r_last_sample <= w_load_word;
            end
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_underrun_load) r_underrun <= 1'b1;
            if (w_drop)          r_overrun  <= 1'b1;
        end
    end

    assign bclk        = r_bclk;
    assign lrclk       = r_lrclk;
    assign sdata       = r_sdata;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_kp_i2s_tx.sv
// Self-checking bench for kp_i2s_tx with the default BCLK_HALF = 1.
// A behavioural model tracks the cycle count since reset, a sample queue and
// the current frame word, and derives the expected pin values arithmetically.
module tb_kp_i2s_tx;

    logic        m_clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] sample_in = 24'd0;
    logic        sample_valid = 1'b0;
    logic        bclk, lrclk, sdata, frame_start, underrun, overrun;

    kp_i2s_tx #(.BCLK_HALF(1)) dut (
        .m_clk(m_clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .frame_start(frame_start),
        .underrun(underrun), .overrun(overrun)
    );

    always #5 m_clk = ~m_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          c = 0;        // rising edges since reset release
    int          tcount = 0;   // rising edges since time zero
    logic [23:0] q[$];
    bit          primed;
    logic [23:0] fw;
    bit          m_under, m_over, m_fs;
    logic [5:0]  exp_v;

    function automatic logic [5:0] obs();
        return {bclk, lrclk, sdata, frame_start, underrun, overrun};
    endfunction

    // Drive the inputs, take one edge, then advance the reference model.
    task tick(input bit rst, input bit v, input logic [23:0] d);
        int bc, p;
        bit sd;
        reset = rst; sample_valid = v; sample_in = d;
        @(posedge m_clk);
        tcount++;
        if (rst) begin
            c = 0; q.delete(); primed = 0; fw = '0; m_under = 0; m_over = 0; m_fs = 0;
        end else begin
            c++;
            m_fs = (c % 128 == 0);
            if (m_fs) begin
                if (q.size() > 0) fw = q.pop_front();
                else if (primed) begin
                    m_under = 1;
`ifndef KP_I2S_UNDERRUN_HOLD_EN
                    fw = '0;
`endif
                end else fw = '0;
            end
            if (v) begin
                if (q.size() < 2) begin q.push_back(d); primed = 1; end
                else m_over = 1;
            end
        end
        bc = (c / 2) % 64;
        p  = bc % 32;
        sd = (p >= 1 && p <= 24) ? fw[24 - p] : 1'b0;
        exp_v = {(c % 2 == 1), (bc >= 32), sd, m_fs, m_under, m_over};
        #1;
    endtask

    task test_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 24'd0);
            n_cmp++;
            if (obs() !== 6'b0) begin
                n_err++; $display("FAIL reset cyc=%0d got=%b exp=000000", i, obs());
            end
        end
    endtask

    task test_full_scale();
        logic [31:0] sl, sr;
        int p;
        sl = '0; sr = '0;
        tick(1, 0, 24'd0);
        for (int i = 0; i < 300; i++) begin
            tick(0, c + 1 == 10, 24'h7FFFFF);
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++; $display("FAIL full_scale c=%0d got=%b exp=%b", c, obs(), exp_v);
            end
            if (c >= 128 && c < 256 && c % 2 == 1) begin
                p = (c / 2) % 32;
                if (c < 192) sl[31 - p] = sdata; else sr[31 - p] = sdata;
            end
            if (c == 255) begin
                n_cmp++;
                if (underrun !== 1'b0) begin
                    n_err++; $display("FAIL full_scale_underrun got=%b exp=0", underrun);
                end
            end
        end
        n_cmp++;
        if (sl !== {1'b0, 24'h7FFFFF, 7'b0} || sr !== {1'b0, 24'h7FFFFF, 7'b0}) begin
            n_err++; $display("FAIL full_scale_slots got L=%h R=%h exp=%h", sl, sr, {1'b0, 24'h7FFFFF, 7'b0});
        end
    endtask

    task test_pattern();
        logic [31:0] sl, sr;
        int p, nt;
        logic pb;
        sl = '0; sr = '0; nt = 0;
        tick(1, 0, 24'd0);
        pb = bclk;
        for (int i = 0; i < 260; i++) begin
            tick(0, c + 1 == 50, 24'h800001);
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++; $display("FAIL pattern c=%0d got=%b exp=%b", c, obs(), exp_v);
            end
            if (bclk != pb) nt++;
            pb = bclk;
            if (c >= 128 && c < 256 && c % 2 == 1) begin
                p = (c / 2) % 32;
                if (c < 192) sl[31 - p] = sdata; else sr[31 - p] = sdata;
            end
            if (c == 192 || c == 256) begin
                n_cmp++;
                if (lrclk !== (c == 192)) begin
                    n_err++; $display("FAIL pattern_lrclk c=%0d got=%b exp=%b", c, lrclk, c == 192);
                end
            end
        end
        n_cmp++;
        if (nt != 260) begin
            n_err++; $display("FAIL pattern_bclk_toggles got=%0d exp=260", nt);
        end
        n_cmp++;
        if (sl !== {1'b0, 24'h800001, 7'b0} || sr !== {1'b0, 24'h800001, 7'b0}) begin
            n_err++; $display("FAIL pattern_slots got L=%h R=%h exp=%h", sl, sr, {1'b0, 24'h800001, 7'b0});
        end
    endtask

    task test_overrun();
        logic [23:0] s[3];
        for (int k = 0; k < 3; k++) s[k] = 24'($urandom);
        tick(1, 0, 24'd0);
        for (int i = 0; i < 520; i++) begin
            if (c + 1 == 130) tick(0, 1, s[0]);
            else if (c + 1 == 140) tick(0, 1, s[1]);
            else if (c + 1 == 150) tick(0, 1, s[2]);
            else tick(0, 0, 24'd0);
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++; $display("FAIL overrun c=%0d got=%b exp=%b", c, obs(), exp_v);
            end
            if (c == 151) begin
                n_cmp++;
                if (overrun !== 1'b1) begin
                    n_err++; $display("FAIL overrun_flag got=%b exp=1", overrun);
                end
            end
            if (c == 300 || c == 420) begin
                n_cmp++;
                if (dut.r_frame_word !== s[c == 300 ? 0 : 1]) begin
                    n_err++; $display("FAIL overrun_frame c=%0d got=%h exp=%h", c, dut.r_frame_word, s[c == 300 ? 0 : 1]);
                end
            end
        end
    endtask

    task test_underrun();
        tick(1, 0, 24'd0);
        for (int i = 0; i < 400; i++) begin
            tick(0, c + 1 == 20, 24'h123456);
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++; $display("FAIL underrun c=%0d got=%b exp=%b", c, obs(), exp_v);
            end
            if (c == 255 || c == 257) begin
                n_cmp++;
                if (underrun !== (c == 257)) begin
                    n_err++; $display("FAIL underrun_flag c=%0d got=%b exp=%b", c, underrun, c == 257);
                end
            end
        end
    endtask

    task test_full_collision();
        tick(1, 0, 24'd0);
        for (int i = 0; i < 400; i++) begin
            if (c + 1 == 20 || c + 1 == 30 || c + 1 == 128 || c + 1 == 140)
                tick(0, 1, 24'($urandom));
            else
                tick(0, 0, 24'd0);
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++; $display("FAIL collision c=%0d got=%b exp=%b", c, obs(), exp_v);
            end
            if (c == 129 || c == 141) begin
                n_cmp++;
                if (overrun !== (c == 141)) begin
                    n_err++; $display("FAIL collision_overrun c=%0d got=%b exp=%b", c, overrun, c == 141);
                end
            end
        end
    endtask

    task test_reset_midframe();
        int last_fs, nfs;
        tick(1, 0, 24'd0);
        for (int i = 0; i < 336; i++) begin
            tick(0, (c + 1) % 128 == 64 || c + 1 == 70 || c + 1 == 75, 24'($urandom));
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++; $display("FAIL midframe_pre c=%0d got=%b exp=%b", c, obs(), exp_v);
            end
        end
        tick(1, 0, 24'd0);
        n_cmp++;
        if (obs() !== 6'b0) begin
            n_err++; $display("FAIL midframe_reset got=%b exp=000000", obs());
        end
        last_fs = -1; nfs = 0;
        for (int i = 0; i < 800; i++) begin
            tick(0, (c + 1) % 128 == 37, 24'($urandom));
            n_cmp++;
            if (obs() !== exp_v) begin
                n_err++; $display("FAIL midframe_post c=%0d got=%b exp=%b", c, obs(), exp_v);
            end
            if (frame_start) begin
                nfs++;
                if (last_fs >= 0) begin
                    n_cmp++;
                    if (tcount - last_fs != 128) begin
                        n_err++; $display("FAIL midframe_period got=%0d exp=128", tcount - last_fs);
                    end
                end
                last_fs = tcount;
            end
        end
        n_cmp++;
        if (nfs != 6) begin
            n_err++; $display("FAIL midframe_frame_count got=%0d exp=6", nfs);
        end
    endtask

    task test_random();
        int rate;
        for (int ph = 0; ph < 4; ph++) begin
            tick(1, 0, 24'd0);
            rate = (ph + 1) * 4;
            for (int i = 0; i < 800; i++) begin
                tick(0, $urandom_range(0, 999) < rate, 24'($urandom));
                n_cmp++;
                if (obs() !== exp_v) begin
                    n_err++; $display("FAIL random ph=%0d c=%0d got=%b exp=%b", ph, c, obs(), exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_pattern();
        test_overrun();
        test_underrun();
        test_full_collision();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/kp_i2s_tx.md
KP_I2S_TX -- requirements
Module: kp_i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_HALF, default 1, meaning m_clk cycles per bclk half-period (range 1..255).
REQ-002 SHALL have port m_clk  input  1  the only clock, audio master clock, nominally 12.288 MHz (128 x 96 kHz); all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sample_in  input  24  signed mono sample from the KP voice output (qout).
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe, already synchronous to m_clk; sample_in is captured in that cycle.
REQ-006 SHALL have port bclk  output  1  I2S bit clock.
REQ-007 SHALL have port lrclk  output  1  I2S word select: 0 = left, 1 = right.
REQ-008 SHALL have port sdata  output  1  I2S serial data.
REQ-009 SHALL have port frame_start  output  1  one-cycle pulse on each frame load.
REQ-010 SHALL have port underrun  output  1  sticky flag: frame load found the FIFO empty after priming.
REQ-011 SHALL have port overrun  output  1  sticky flag: a sample was dropped because the FIFO was full.

Function
REQ-012 SHALL run a divider 0..BCLK_HALF-1 and toggle bclk when the divider wraps; with the default, bclk = m_clk/2 = 6.144 MHz.
REQ-013 SHALL advance a 6-bit bit counter (0..63) on every bclk falling transition, giving 64 bclk per frame and a 96 kHz frame rate with the defaults.
REQ-014 SHALL update lrclk and sdata only on bclk falling transitions; lrclk = bit_cnt[5].
REQ-015 SHALL serialise each 32-bit slot, slot position p = bit_cnt[4:0], as follows: p=0 outputs 0 (I2S one-bit delay); p=1..24 output frame_word[23] down to frame_word[0], MSB first; p=25..31 output 0.
REQ-016 SHALL send the same frame_word in both the left and right slots (mono duplicated).
REQ-017 SHALL use a 2-entry FIFO: push on sample_valid when not full; pop at frame load.
REQ-018 SHALL perform frame load on the falling transition where bit_cnt wraps 63->0: pop the FIFO into frame_word, and pulse frame_start for that m_clk cycle.
REQ-019 SHALL drop the incoming sample and set overrun when sample_valid arrives while the FIFO is full, unless a pop occurs in the same cycle; a simultaneous pop and push on a full FIFO SHALL accept the push.
REQ-020 SHALL set the FIFO "primed" state on the first accepted push after reset. Frame loads on an empty FIFO before priming SHALL load 0 and SHALL NOT set underrun.
REQ-021 SHALL set underrun when a frame load finds the FIFO empty after priming; frame_word is then chosen per REQ-026.
REQ-022 SHALL keep underrun and overrun set until reset.
REQ-023 SHALL give a latency from sample_valid (FIFO empty, primed) to the MSB on sdata of: wait to the next frame load, then one bclk period.

Reset
REQ-024 SHALL, while reset is high at a rising m_clk edge, force: bclk=0, lrclk=0, sdata=0, frame_start=0, underrun=0, overrun=0, divider=0, bit_cnt=0, FIFO empty, primed=0, frame_word=0, last-sample register=0.
REQ-025 SHALL, when reset is asserted mid-frame, abandon the frame and FIFO contents, and start the next frame at bit_cnt=0 with lrclk=0 after release.

Configuration
REQ-026 SHALL support the macro KP_I2S_UNDERRUN_HOLD_EN. When defined, an underrun frame load repeats the last transmitted frame_word. When undefined, an underrun frame load sends 0. Both variants set underrun identically.

Verification
REQ-027 SHALL cover: reset, then sample_in=24'h7FFFFF with one strobe before the first frame load -> left and right slots each show 0, then 24 ones, then 7 zeros; underrun=0.
REQ-028 SHALL cover: sample 24'h800001 -> slot bits p=1..24 read 1000_0000_0000_0000_0000_0001; lrclk toggles at bit_cnt 32 and 0; bclk period = 2 m_clk cycles.
REQ-029 SHALL cover: three strobes within one frame -> the third is dropped and overrun=1; the next two frames carry samples 1 and 2.
REQ-030 SHALL cover: one sample 24'h123456, then no further strobes -> the next frame sets underrun=1 and carries 24'h123456 with the macro defined, 24'h000000 without it.
REQ-031 SHALL cover: a strobe in the same m_clk cycle as a frame load with the FIFO full -> no overrun, and the FIFO stays at 2 entries.
REQ-032 SHALL cover: reset pulsed at bit_cnt=40 -> all outputs 0 the next cycle, and the flags clear; after a 96 kHz strobe stream resumes, frame_start recurs every 128 m_clk cycles.
